// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the tick_gen programmable tick source.
package tick_gen_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDonePulse
   } state_e;

   localparam logic MODE_CONT  = 1'b0;
   localparam logic MODE_BURST = 1'b1;

   // Widest divider the clamp helper accepts; callers cast to and from their own width.
   localparam int unsigned MaxDivW = 64;

   function automatic logic [MaxDivW-1:0] clamp_div(input logic [MaxDivW-1:0] d);
      return (d == '0) ? MaxDivW'(1) : d;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Reloadable down-counter: wraps (and self-reloads) when enabled at zero.
module tick_prescaler #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             wrap_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   assign wrap_o = en_i && !load_i && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i) begin
         cnt_d = (cnt_q == '0) ? load_val_i : cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tick_gen.sv
// Programmable tick source: continuous or N-tick burst divided from clk_i.
// Define TICK_GEN_LIVE_DIV_EN to re-sample div_i at every prescaler reload.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned CWIDTH = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              mode_i,
   input  logic [WIDTH-1:0]  div_i,
   input  logic [CWIDTH-1:0] burst_n_i,
   output logic              tick_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CWIDTH-1:0] tick_count_o
);

   state_e            state_q;
   logic              mode_q;
   logic [CWIDTH-1:0] n_q;
   logic [CWIDTH-1:0] count_q;
   logic              tick_q, busy_q, done_q;

   logic              start_ok, presc_en, wrap;
   logic [WIDTH-1:0]  div_clamped, reload_val, load_val;
   logic [CWIDTH-1:0] count_inc;

   // Stop always beats a simultaneous start.
   assign start_ok    = start_i && !stop_i;
   assign presc_en    = (state_q == StRun) && enable_i && !stop_i && !start_i;
   assign div_clamped = WIDTH'(clamp_div(MaxDivW'(div_i)));
   assign count_inc   = count_q + CWIDTH'(1);

`ifdef TICK_GEN_LIVE_DIV_EN
   assign reload_val = div_clamped - WIDTH'(1);
`else
   logic [WIDTH-1:0] div_q;

   assign reload_val = div_q - WIDTH'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q <= '0;
      end else if (start_ok) begin
         div_q <= div_clamped;
      end
   end
`endif

   assign load_val = start_ok ? (div_clamped - WIDTH'(1)) : reload_val;

   tick_prescaler #(
      .WIDTH (WIDTH)
   ) u_prescaler (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (start_ok),
      .load_val_i (load_val),
      .en_i       (presc_en),
      .wrap_o     (wrap)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         mode_q  <= MODE_CONT;
         n_q     <= '0;
         count_q <= '0;
         tick_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         done_q <= (state_q == StDonePulse);
         if (start_ok) begin
            mode_q  <= mode_i;
            n_q     <= burst_n_i;
            count_q <= '0;
            // A zero-length burst reports done without ever running.
            if (mode_i == MODE_BURST && burst_n_i == '0) begin
               state_q <= StDonePulse;
               busy_q  <= 1'b0;
            end else begin
               state_q <= StRun;
               busy_q  <= 1'b1;
            end
         end else begin
            unique case (state_q)
               StRun: begin
                  if (stop_i) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end else if (wrap) begin
                     tick_q  <= 1'b1;
                     count_q <= count_inc;
                     if (mode_q == MODE_BURST && count_inc == n_q) begin
                        state_q <= StDonePulse;
                     end
                  end
               end
               StDonePulse: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
               StIdle: begin
                  busy_q <= 1'b0;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign tick_o       = tick_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign tick_count_o = count_q;

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: reference model pushes expected outputs, monitor pops/compares.
module tb_tick_gen;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst, enable, start, stop, mode;
   logic [W-1:0]  div;
   logic [CW-1:0] burst_n;
   logic          tick, busy, done;
   logic [CW-1:0] tick_count;

   tick_gen #(
      .WIDTH  (W),
      .CWIDTH (CW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .enable_i     (enable),
      .start_i      (start),
      .stop_i       (stop),
      .mode_i       (mode),
      .div_i        (div),
      .burst_n_i    (burst_n),
      .tick_o       (tick),
      .busy_o       (busy),
      .done_o       (done),
      .tick_count_o (tick_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit tick;
      bit busy;
      bit done;
      int cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tick_edges[$];
   int   done_edges[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   base = 0;
   bit   mon_on = 1'b0;

   // Reference model state: time since last tick counted in enabled cycles.
   bit m_run, m_mode, m_pend, m_hold;
   int m_period, m_elapsed, m_cnt, m_n;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endfunction

   function automatic void chk_edges(string name, int got[$], int n, int e0, int e1, int e2,
                                     int e3);
      int  e[4];
      bit  ok;
      string s;
      e = '{e0, e1, e2, e3};
      ok = (got.size() == n);
      for (int i = 0; i < n && ok; i++) ok = (got[i] == e[i]);
      s = "";
      foreach (got[i]) s = $sformatf("%s %0d", s, got[i]);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got edges [%s ] expected %0d edges starting %0d", name, s, n, e0);
      end
   endfunction

   function automatic int clampi(int d);
      return (d == 0) ? 1 : d;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (mon_on) begin
         e.tick = 0;
         e.done = m_pend;
         m_pend = 0;
         m_hold = 0;
         if (rst) begin
            m_run = 0;
            m_cnt = 0;
            e.done = 0;
         end else if (start && !stop) begin
            m_period  = clampi(int'(div));
            m_mode    = mode;
            m_n       = int'(burst_n);
            m_cnt     = 0;
            m_elapsed = 0;
            if (mode && burst_n == 0) begin
               m_run  = 0;
               m_pend = 1;
            end else begin
               m_run = 1;
            end
         end else if (m_run) begin
            if (stop) begin
               m_run = 0;
            end else if (enable) begin
               m_elapsed++;
               if (m_elapsed == m_period) begin
                  e.tick    = 1;
                  m_cnt     = (m_cnt + 1) % (1 << CW);
                  m_elapsed = 0;
`ifdef TICK_GEN_LIVE_DIV_EN
                  m_period  = clampi(int'(div));
`endif
                  if (m_mode && m_cnt == m_n) begin
                     m_run  = 0;
                     m_pend = 1;
                     m_hold = 1;
                  end
               end
            end
         end
         e.busy = m_run || m_hold;
         e.cnt  = m_cnt;
         exp_q.push_back(e);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("tick", 32'(tick), 32'(e.tick));
         chk("busy", 32'(busy), 32'(e.busy));
         chk("done", 32'(done), 32'(e.done));
         chk("tick_count", 32'(tick_count), e.cnt);
         if (tick === 1'b1) tick_edges.push_back(cyc - base);
         if (done === 1'b1) done_edges.push_back(cyc - base);
      end
   end

   task automatic step(int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go(int d, bit m, int n);
      div     = W'(d);
      mode    = m;
      burst_n = CW'(n);
      start   = 1'b1;
      tick_edges.delete();
      done_edges.delete();
      base = cyc + 1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
      div = '0; burst_n = '0;
      m_run = 0; m_mode = 0; m_pend = 0; m_hold = 0;
      m_period = 1; m_elapsed = 0; m_cnt = 0; m_n = 0;
      step();
      mon_on = 1'b1;
      step(2);
      rst = 1'b0;
      step();

      // Burst basic
      go(4, 1, 3);
      step(16);
      chk_edges("burst_ticks", tick_edges, 3, 4, 8, 12, 0);
      chk_edges("burst_done", done_edges, 1, 13, 0, 0, 0);
      chk("burst_final_count", 32'(tick_count), 3);

      // Pause for 7 cycles from edge 2
      go(5, 1, 2);
      step();
      enable = 1'b0;
      step(7);
      enable = 1'b1;
      step(14);
      chk_edges("pause_ticks", tick_edges, 2, 12, 17, 0, 0);
      chk_edges("pause_done", done_edges, 1, 18, 0, 0, 0);

      // Zero-length burst
      go(3, 1, 0);
      step(5);
      chk_edges("n0_ticks", tick_edges, 0, 0, 0, 0, 0);
      chk_edges("n0_done", done_edges, 1, 1, 0, 0, 0);

      // div=0 behaves as div=1
      go(0, 1, 2);
      step(5);
      chk_edges("div0_ticks", tick_edges, 2, 1, 2, 0, 0);
      chk_edges("div0_done", done_edges, 1, 3, 0, 0, 0);

      // Restart at edge 6
      go(4, 1, 3);
      step(5);
      start = 1'b1;
      step();
      start = 1'b0;
      step(16);
      chk_edges("restart_ticks", tick_edges, 4, 4, 10, 14, 18);
      chk_edges("restart_done", done_edges, 1, 19, 0, 0, 0);

      // Continuous wrap, then stop
      go(1, 0, 0);
      step(16);
      chk("cont_wrap_count", 32'(tick_count), 0);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("cont_stop_busy", 32'(busy), 0);
      step(4);
      chk_edges("cont_no_done", done_edges, 0, 0, 0, 0, 0);

      // start+stop together in RUN
      go(3, 0, 0);
      step(3);
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("startstop_busy", 32'(busy), 0);
      step(5);
      chk_edges("startstop_no_done", done_edges, 0, 0, 0, 0, 0);

      // Reset mid-run
      go(2, 0, 0);
      step(5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_outputs", {29'(tick_count), tick, busy, done}, 0);
      step(2);

      // Live divider change after start
      go(4, 1, 3);
      div = W'(2);
      step(16);
`ifdef TICK_GEN_LIVE_DIV_EN
      chk_edges("live_ticks", tick_edges, 3, 4, 6, 8, 0);
`else
      chk_edges("live_ticks", tick_edges, 3, 4, 8, 12, 0);
`endif

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 299) == 0);
         start   = ($urandom_range(0, 39) == 0);
         stop    = ($urandom_range(0, 79) == 0);
         enable  = ($urandom_range(0, 9) != 0);
         mode    = 1'($urandom_range(0, 1));
         div     = W'($urandom_range(0, 6));
         burst_n = CW'($urandom_range(0, 6));
         step();
      end
      rst = 1'b0; start = 1'b0; stop = 1'b0;
      step(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
